control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Multicycle control unit that drives the 16-bit register/ALU datapath. It issues DR/SA/SB/FS and the mux/write selects, and it owns the 6-bit program counter.
- Fetches 20-bit instructions from a synchronous instruction ROM, decodes them, and sequences ALU, immediate, load, store, branch, jump and jump-and-link operations.
- Uses the datapath Z flag for conditional branches.
- Sits between the instruction ROM, the data memory and the datapath, as the initiator for all datapath control.

Parameters:
- PC_W, 6, program counter and instruction-address width.
- IW, 20, instruction width. Fields: [19:16] op, [15:12] FS, [11:8] DR, [7:4] SA, [3:0] SB.

Ports:
- clk_main  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_in  in  IW  ROM read data; valid one cycle after instr_addr is presented.
- Z  in  1  datapath zero flag, combinational from the current SA/SB/FS/MB.
- instr_addr  out  PC_W  ROM address (equals PC).
- PC  out  PC_W  program counter to the datapath; the datapath forms PC+1 as the link value.
- DR, SA, SB  out  4 each  register addresses.
- FS  out  4  ALU function select.
- MB  out  1  1 selects the immediate {8'b0,SA,SB}.
- MD  out  1  1 selects memory data.
- RW  out  1  register-file write enable.
- MP  out  1  1 writes PC+1 (link).
- mem_we  out  1  data-memory write strobe; address = R[SA], data = R[SB].
- halted  out  1  core stopped.
- illegal  out  1  sticky; set on an undefined opcode.

Behaviour:
- Reset (synchronous, high at a clk_main edge):
  - State = FETCH, PC = 0, IR = 0.
  - halted = 0, illegal = 0.
  - RW = MB = MD = MP = mem_we = 0.
  - DR/SA/SB/FS = 0.
  - Reset overrides every state, including mid-LD; no register or memory write occurs in the reset cycle.
- FSM states: FETCH, DECODE, EXEC, MEM, HALT.
  - FETCH: instr_addr = PC. Next state DECODE.
  - DECODE: IR <= instr_in. Next state EXEC.
  - EXEC: drive the controls decoded from IR (Moore outputs, combinational from state and IR). Update PC at the end of the cycle. Next state is FETCH, except LD goes to MEM and HALT goes to HALT.
  - MEM (LD only): MD = 1, RW = 1; DR/SA held from IR. Then PC <= PC+1 and next state FETCH.
  - HALT: all enables 0; PC frozen; remains here until reset.
- Outside EXEC and MEM, RW, MB, MD, MP and mem_we are all 0.
- Opcodes (all executed in EXEC unless noted):
  - 0 NOP: no enables.
  - 1 ALU: RW = 1.
  - 2 ALUI: MB = 1, RW = 1.
  - 3 LD: EXEC presents address R[SA] with RW = 0. MEM writes DataIn to R[DR]. Total 4 cycles.
  - 4 ST: mem_we = 1 for exactly one cycle.
  - 5 BRZ: RW = 0. Z is evaluated for FS on R[SA] and R[SB]. If Z = 1, PC <= {DR[1:0],SB}; otherwise PC+1.
  - 6 BRNZ: as BRZ with the condition inverted.
  - 7 JMP: PC <= {SA[1:0],SB}.
  - 8 JAL: MP = 1, RW = 1 (R[DR] <= old PC+1); PC <= {SA[1:0],SB}.
  - F HALT: next state HALT; halted = 1 from the next cycle.
  - 9–E: treated as NOP; illegal <= 1 (sticky until reset).
- In EXEC, DR/SA/SB/FS always equal the IR fields.
- PC arithmetic is modulo 2^PC_W: 63 + 1 wraps to 0. Branch and jump targets are absolute.
- Cycle counts: 3 cycles per instruction; LD takes 4.

Decomposition:
- Package cu_pkg:
  - opcode constants (OP_NOP … OP_HALT);
  - state enum;
  - IR field bit positions;
  - PC_W/IW defaults.
- Sub-module instr_decoder: purely combinational; maps (state, IR, Z) to the control outputs, next-PC select and next state.
- Top level holds the state, PC, IR and illegal registers.

Test Plan:
- Reset: hold reset for 2 cycles, then release. First cycle: PC = 0, instr_addr = 0, RW = 0, mem_we = 0, halted = 0. After DECODE, IR = ROM[0].
- ALUI: ROM[0] = 0x22107. In EXEC (cycle 3): MB = 1, RW = 1, DR = 1, SA = 0, SB = 7, FS = 2. Next FETCH has PC = 1.
- LD/ST: ROM[1] = 0x30240.
  - EXEC: SA = 4, RW = 0, MD = 0.
  - MEM: MD = 1, RW = 1, DR = 2.
  - ST 0x40045: mem_we high for exactly one cycle with SA = 4, SB = 5.
- Branch: BRZ 0x50235 at PC = 7 (target {2'b10,4'h5} = 37).
  - With Z = 1 in EXEC, the next PC is 37.
  - Repeat with Z = 0: next PC is 8, and RW stays 0 throughout.
- JAL/wrap: JAL 0x80413 at PC = 10.
  - EXEC: MP = 1, RW = 1, DR = 4 (link value 11). Next PC = {2'b01,4'h3} = 19.
  - NOP at PC = 63: next PC = 0.
- Halt/illegal/reset:
  - Opcode 0xC at PC = 0 sets illegal = 1, with no enables asserted, and PC advances.
  - Opcode 0xF then sets halted = 1; PC is frozen for 10+ cycles.
  - Assert reset during a LD MEM cycle: RW = 0 that cycle, PC = 0, illegal = 0.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle control sequencer:
// opcodes, FSM states, IR field positions and the control bundle.
package cu_pkg;

    localparam int PC_W_DEF = 6;
    localparam int IW_DEF   = 20;

    localparam int OP_LSB = 16;
    localparam int FS_LSB = 12;
    localparam int DR_LSB = 8;
    localparam int SA_LSB = 4;
    localparam int SB_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_ALUI = 4'h2;
    localparam logic [3:0] OP_LD   = 4'h3;
    localparam logic [3:0] OP_ST   = 4'h4;
    localparam logic [3:0] OP_BRZ  = 4'h5;
    localparam logic [3:0] OP_BRNZ = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JAL  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_TGT
    } pc_sel_e;

    typedef struct packed {
        logic [3:0] dr;
        logic [3:0] sa;
        logic [3:0] sb;
        logic [3:0] fs;
        logic       mb;
        logic       md;
        logic       rw;
        logic       mp;
        logic       mem_we;
    } ctrl_t;

    function automatic logic [3:0] fld(
        input logic [IW_DEF-1:0] ir,
        input int                lsb
    );
        return ir[lsb +: 4];
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of (state, IR, Z) into datapath controls,
// the next-PC selection and the next FSM state.
module instr_decoder
    import cu_pkg::*;
(
    input  state_e            state,
    input  logic [IW_DEF-1:0] ir,
    input  logic              z,
    output ctrl_t             ctrl,
    output pc_sel_e           pc_sel,
    output logic [5:0]        pc_tgt,
    output state_e            state_nxt,
    output logic              op_illegal
);

    logic [3:0] op;
    logic [3:0] f_dr;
    logic [3:0] f_sa;
    logic [3:0] f_sb;
    logic [3:0] f_fs;

    always_comb begin
        op   = fld(ir, OP_LSB);
        f_dr = fld(ir, DR_LSB);
        f_sa = fld(ir, SA_LSB);
        f_sb = fld(ir, SB_LSB);
        f_fs = fld(ir, FS_LSB);

        ctrl       = '0;
        pc_sel     = PC_HOLD;
        pc_tgt     = '0;
        state_nxt  = state;
        op_illegal = 1'b0;

        unique case (state)
            ST_FETCH:  state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC: begin
                ctrl.dr   = f_dr;
                ctrl.sa   = f_sa;
                ctrl.sb   = f_sb;
                ctrl.fs   = f_fs;
                state_nxt = ST_FETCH;
                pc_sel    = PC_INC;
                unique case (op)
                    OP_NOP: ;
                    OP_ALU: ctrl.rw = 1'b1;
                    OP_ALUI: begin
                        ctrl.mb = 1'b1;
                        ctrl.rw = 1'b1;
                    end
                    // PC advances only once the load completes in MEM
                    OP_LD: begin
                        state_nxt = ST_MEM;
                        pc_sel    = PC_HOLD;
                    end
                    OP_ST: ctrl.mem_we = 1'b1;
                    OP_BRZ: begin
                        pc_tgt = {f_dr[1:0], f_sb};
                        if (z)
                            pc_sel = PC_TGT;
                    end
                    OP_BRNZ: begin
                        pc_tgt = {f_dr[1:0], f_sb};
                        if (!z)
                            pc_sel = PC_TGT;
                    end
                    OP_JMP: begin
                        pc_tgt = {f_sa[1:0], f_sb};
                        pc_sel = PC_TGT;
                    end
                    OP_JAL: begin
                        ctrl.mp = 1'b1;
                        ctrl.rw = 1'b1;
                        pc_tgt  = {f_sa[1:0], f_sb};
                        pc_sel  = PC_TGT;
                    end
                    OP_HALT: begin
                        state_nxt = ST_HALT;
                        pc_sel    = PC_HOLD;
                    end
                    default: op_illegal = 1'b1;
                endcase
            end
            ST_MEM: begin
                ctrl.dr   = f_dr;
                ctrl.sa   = f_sa;
                ctrl.md   = 1'b1;
                ctrl.rw   = 1'b1;
                pc_sel    = PC_INC;
                state_nxt = ST_FETCH;
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_FETCH;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multicycle control unit: owns state, PC, IR and the sticky
// illegal flag; decode is delegated to instr_decoder.
module control_sequencer #(
    parameter int PC_W = 6,
    parameter int IW   = 20
) (
    input  logic            clk_main,
    input  logic            reset,
    input  logic [IW-1:0]   instr_in,
    input  logic            Z,
    output logic [PC_W-1:0] instr_addr,
    output logic [PC_W-1:0] PC,
    output logic [3:0]      DR,
    output logic [3:0]      SA,
    output logic [3:0]      SB,
    output logic [3:0]      FS,
    output logic            MB,
    output logic            MD,
    output logic            RW,
    output logic            MP,
    output logic            mem_we,
    output logic            halted,
    output logic            illegal
);
    import cu_pkg::*;

    state_e          state_q;
    state_e          state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [IW-1:0]   ir_q;
    logic [IW-1:0]   ir_d;
    logic            illegal_q;
    logic            illegal_d;

    ctrl_t   ctrl;
    ctrl_t   ctrl_o;
    pc_sel_e pc_sel;
    logic [5:0] pc_tgt;
    state_e  state_nxt;
    logic    op_illegal;

    instr_decoder u_dec (
        .state      (state_q),
        .ir         (ir_q),
        .z          (Z),
        .ctrl       (ctrl),
        .pc_sel     (pc_sel),
        .pc_tgt     (pc_tgt),
        .state_nxt  (state_nxt),
        .op_illegal (op_illegal)
    );

    always_comb begin
        state_d   = state_nxt;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q | op_illegal;
        if (state_q == ST_DECODE)
            ir_d = instr_in;
        unique case (pc_sel)
            PC_INC:  pc_d = pc_q + PC_W'(1);
            PC_TGT:  pc_d = PC_W'(pc_tgt);
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk_main) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // Suppress every strobe while reset is high so an interrupted
    // load cannot write the register file on the reset edge.
    always_comb begin
        ctrl_o = reset ? '0 : ctrl;
    end

    assign DR         = ctrl_o.dr;
    assign SA         = ctrl_o.sa;
    assign SB         = ctrl_o.sb;
    assign FS         = ctrl_o.fs;
    assign MB         = ctrl_o.mb;
    assign MD         = ctrl_o.md;
    assign RW         = ctrl_o.rw;
    assign MP         = ctrl_o.mp;
    assign mem_we     = ctrl_o.mem_we;
    assign instr_addr = pc_q;
    assign PC         = pc_q;
    assign halted     = (state_q == ST_HALT);
    assign illegal    = illegal_q;

endmodule
